// File: rtl/peri_bus_pkg.sv
// rtl/peri_bus_pkg.sv - shared types and constants for the peripheral bus master
package peri_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } bus_state_e;

    localparam logic [31:0] GPIO_ADDR_0 = 32'h0300_0000;
    localparam logic [31:0] GPIO_ADDR_1 = 32'h0300_0004;
    localparam logic [31:0] GPIO_ADDR_2 = 32'h0300_0008;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/peri_bus_wdog.sv
// rtl/peri_bus_wdog.sv - saturating bus-cycle timeout counter
module peri_bus_wdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != CNT_W'(TIMEOUT_CYCLES))) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Expiry is flagged during the last allowed waiting cycle so the abort lands on its closing edge.
    assign expired = (r_count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/peri_bus_master.sv
// rtl/peri_bus_master.sv - command/response to native valid/ready peripheral bus bridge
module peri_bus_master
    import peri_bus_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_addr,
    input  logic [3:0]  cmd_wstrb,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    bus_state_e  r_state;
    bus_state_e  w_next_state;
    logic [31:0] r_mem_addr;
    logic [3:0]  r_mem_wstrb;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic        w_expired;
    logic        w_aligned;

    assign w_aligned = (cmd_addr[1:0] == 2'b00);

    peri_bus_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk    (clk),
        .resetn (resetn),
        .clear  (r_state != ST_REQ),
        .enable (r_state == ST_REQ),
        .expired(w_expired)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_next_state = w_aligned ? ST_REQ : ST_RESP;
                end
            end
            ST_REQ: begin
                if (mem_ready || w_expired) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Completion beats timeout: mem_ready is tested first in REQ.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mem_addr  <= '0;
            r_mem_wstrb <= '0;
            r_mem_wdata <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (cmd_valid && w_aligned) begin
                        r_mem_addr  <= cmd_addr;
                        r_mem_wstrb <= cmd_wstrb;
                        r_mem_wdata <= cmd_wdata;
                    end else if (cmd_valid) begin
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= ERR_RDATA;
                    end
                end
                ST_REQ: begin
                    if (mem_ready) begin
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= (r_mem_wstrb == 4'b0000) ? mem_rdata : 32'h0;
                    end else if (w_expired) begin
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= ERR_RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready = resetn && (r_state == ST_IDLE);
    assign mem_valid = (r_state == ST_REQ);
    assign rsp_valid = (r_state == ST_RESP);
    assign mem_addr  = r_mem_addr;
    assign mem_wstrb = r_mem_wstrb;
    assign mem_wdata = r_mem_wdata;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_peri_bus_master.sv
// tb/tb_peri_bus_master.sv - randomized self-checking bench for peri_bus_master
module tb_peri_bus_master;

    localparam int          T_OUT = 4;
    localparam logic [31:0] ERR_V = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    peri_bus_master #(
        .TIMEOUT_CYCLES(T_OUT),
        .ERR_RDATA     (ERR_V)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_addr (cmd_addr),
        .cmd_wstrb(cmd_wstrb),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .mem_valid(mem_valid),
        .mem_addr (mem_addr),
        .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One command; the responder raises ready lat cycles after valid rises (optionally one extra
    // cycle), and the response is left unconsumed for hold cycles.
    task automatic do_txn(input logic [31:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata,
                          input int lat, input bit sticky, input int hold);
        logic [31:0] rd;
        bit          aligned;
        int          d;
        logic [31:0] exp_rdata;
        logic        exp_err;
        rd      = $urandom;
        aligned = (addr[1:0] == 2'b00);
        if (!aligned) begin
            d = 0;
        end else if (lat < T_OUT) begin
            d = lat + 1;
        end else begin
            d = T_OUT;
        end
        exp_err   = !aligned || (lat >= T_OUT);
        exp_rdata = exp_err ? ERR_V : ((wstrb == 4'b0000) ? rd : 32'h0);

        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_wstrb = wstrb;
        cmd_wdata = wdata;
        check("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;

        for (int c = 1; c <= d + 1 + hold; c++) begin
            @(negedge clk);
            check("mem_valid", {31'b0, mem_valid}, {31'b0, (aligned && c <= d)});
            if (aligned && c <= d) begin
                check("mem_addr", mem_addr, addr);
                check("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, wstrb});
                check("mem_wdata", mem_wdata, wdata);
            end
            check("rsp_valid", {31'b0, rsp_valid}, {31'b0, (c > d)});
            check("cmd_ready_busy", {31'b0, cmd_ready}, 32'd0);
            if (c > d) begin
                check("rsp_err", {31'b0, rsp_err}, {31'b0, exp_err});
                check("rsp_rdata", rsp_rdata, exp_rdata);
            end
            mem_ready = aligned && ((c == lat + 1) || (sticky && c == lat + 2));
            mem_rdata = mem_ready ? rd : ~rd;
            rsp_ready = (c == d + 1 + hold);
        end
        @(negedge clk);
        mem_ready = 1'b0;
        rsp_ready = 1'b0;
        check("rsp_valid_done", {31'b0, rsp_valid}, 32'd0);
        check("mem_valid_done", {31'b0, mem_valid}, 32'd0);
        check("cmd_ready_back", {31'b0, cmd_ready}, 32'd1);
    endtask

    task automatic reset_in_req();
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr  = 32'h0300_0000;
        cmd_wstrb = 4'b1111;
        cmd_wdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check("rst_mem_valid_pre", {31'b0, mem_valid}, 32'd1);
        #2 resetn = 1'b0;
        #1;
        check("rst_mem_valid_async", {31'b0, mem_valid}, 32'd0);
        check("rst_cmd_ready_low", {31'b0, cmd_ready}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        end
        resetn = 1'b1;
        @(negedge clk);
        check("rst_rsp_after", {31'b0, rsp_valid}, 32'd0);
        check("rst_cmd_ready_after", {31'b0, cmd_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  s;
        repeat (2) @(negedge clk);
        check("reset_mem_valid", {31'b0, mem_valid}, 32'd0);
        check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        check("reset_mem_addr", mem_addr, 32'h0);
        check("reset_mem_wstrb", {28'b0, mem_wstrb}, 32'h0);
        check("reset_mem_wdata", mem_wdata, 32'h0);
        check("reset_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        check("post_reset_cmd_ready", {31'b0, cmd_ready}, 32'd1);

        do_txn(32'h0300_0008, 4'b0001, 32'h0000_005A, 1, 1'b0, 0);
        do_txn(32'h0300_0004, 4'b0000, 32'h0, 3, 1'b0, 1);
        do_txn(32'h0300_0000, 4'b0000, 32'h0, 20, 1'b0, 0);
        do_txn(32'h0300_0002, 4'b0011, 32'h1111_2222, 0, 1'b0, 0);
        do_txn(32'h0300_0008, 4'b1111, 32'hA5A5_A5A5, 0, 1'b1, 5);
        reset_in_req();
        do_txn(32'h0300_0004, 4'b0000, 32'h0, 2, 1'b0, 0);

        for (int k = 0; k < 60; k++) begin
            a = 32'h0300_0000 + ($urandom_range(0, 15) << 2);
            if ($urandom_range(0, 5) == 0) begin
                a[1:0] = 2'($urandom_range(1, 3));
            end
            s = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            do_txn(a, s, $urandom, $urandom_range(0, 6), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/peri_bus_master.md
PERI_BUS_MASTER -- requirements
Module: peri_bus_master

Interface
REQ-001 The module SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of cycles mem_valid stays high without mem_ready before the transaction aborts (legal range 1..65535).
REQ-002 The module SHALL have parameter ERR_RDATA, default 32'hDEAD_BEEF, meaning the rsp_rdata value returned on any error response.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 resetn  in  1  reset, asynchronous and active-low.
REQ-005 cmd_valid  in  1  command offered.
REQ-006 cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-007 cmd_addr  in  32  byte address.
REQ-008 cmd_wstrb  in  4  byte enables; 4'b0000 means read.
REQ-009 cmd_wdata  in  32  write data.
REQ-010 rsp_valid  out  1  response available.
REQ-011 rsp_ready  in  1  response consumed when rsp_valid and rsp_ready are both high.
REQ-012 rsp_rdata  out  32  read data (0 for a successful write, ERR_RDATA on error).
REQ-013 rsp_err  out  1  timeout or misaligned address.
REQ-014 mem_valid, mem_addr[31:0], mem_wstrb[3:0], mem_wdata[31:0]  out  native bus request towards peripherals.
REQ-015 mem_ready  in  1, mem_rdata  in  32  native bus completion from the addressed peripheral.

Function
REQ-016 FSM states SHALL be IDLE, REQ, RESP; reset state IDLE.
REQ-017 IDLE: cmd_ready=1; on accept with cmd_addr[1:0]==0, latch addr/wstrb/wdata into the mem_* registers, set mem_valid=1 the next cycle, clear the timer, go REQ.
REQ-018 IDLE, accept with cmd_addr[1:0]!=0: issue no bus cycle, load rsp_err=1 and rsp_rdata=ERR_RDATA, go RESP.
REQ-019 REQ: cmd_ready=0; mem_addr, mem_wstrb and mem_wdata SHALL stay stable while mem_valid=1.
REQ-020 REQ and mem_ready=1: clear mem_valid at that edge; rsp_rdata = mem_rdata if read, else 0; rsp_err=0; go RESP.
REQ-021 REQ, mem_ready=0 and timer==TIMEOUT_CYCLES-1: clear mem_valid; rsp_err=1; rsp_rdata=ERR_RDATA; go RESP.
REQ-022 mem_ready SHALL be ignored whenever mem_valid=0; a responder that holds ready one extra cycle after valid falls SHALL NOT produce a second completion.
REQ-023 RESP: rsp_valid=1, cmd_ready=0; on rsp_ready=1 go IDLE; rsp_* stable until consumed.
REQ-024 mem_valid SHALL be low for at least one cycle between consecutive transactions; the RESP→IDLE→REQ path guarantees this.
REQ-025 Latency: cmd accept at edge N → mem_valid high from N+1; mem_ready sampled at edge M → rsp_valid high from M+1.
REQ-026 Timer SHALL count only in REQ, saturate, be $clog2(TIMEOUT_CYCLES+1) bits wide, and clear on every REQ entry.
REQ-027 mem_ready arriving in the same cycle as the timeout condition SHALL win: a successful completion, no error.

Reset
REQ-028 Asserting resetn low SHALL immediately force state=IDLE, mem_valid=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_addr=0, mem_wstrb=0, mem_wdata=0, timer=0; cmd_ready=0 while resetn is low.
REQ-029 Reset mid-transaction SHALL abandon it with no response generated; after deassertion the first cycle is IDLE with cmd_ready=1.

Structure
REQ-030 Package peri_bus_pkg SHALL hold the FSM state enum, the GPIO register addresses 32'h0300_0000, 32'h0300_0004 and 32'h0300_0008, and the ERR_RDATA default.
REQ-031 The timeout counter SHALL be the one sub-module, peri_bus_wdog (inputs clear, enable; output expired).

Verification
REQ-032 Write: cmd to 0x0300_0008, wstrb 4'b0001, wdata 0x5A; the responder raises ready 1 cycle after valid → mem_valid high exactly 1 cycle after accept, then rsp_valid with rsp_err=0 and rsp_rdata=0.
REQ-033 Read: cmd to 0x0300_0004, wstrb 0; the responder returns 0x1234_5678 after 3 cycles → rsp_rdata=0x1234_5678, rsp_err=0.
REQ-034 Timeout: TIMEOUT_CYCLES=4 and the responder is silent → mem_valid high exactly 4 cycles, then rsp_err=1 and rsp_rdata=0xDEAD_BEEF.
REQ-035 Misaligned: cmd_addr 0x0300_0002 → mem_valid never rises; rsp_err=1 the next cycle.
REQ-036 Sticky ready: the responder holds ready 1 cycle past valid and rsp_ready is held low 5 cycles → exactly one response, and rsp_* stable for all 5 cycles.
REQ-037 Reset in REQ: resetn pulsed low while mem_valid=1 → mem_valid=0 asynchronously, rsp_valid never asserts, the next command completes normally.
